// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer.
// Letters are MSB-first patterns (1 = dash) with the symbol count alongside.
package morse_pkg;

  localparam int unsigned LETTER_W         = 3;
  localparam int unsigned PAT_W            = 4;
  localparam int unsigned LEN_W            = 3;
  localparam int unsigned CNT_W            = 3;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned LETTER_GAP_UNITS = 3;

  typedef enum logic [2:0] {
    IDLE,
    RESTART,
    ON,
    OFF,
    FIN,
    LETTER_GAP
  } state_t;

  // Element that follows the current one-cycle RESTART.
  typedef enum logic [1:0] {
    NXT_ON,
    NXT_OFF,
    NXT_LGAP
  } next_el_t;

  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] length;
  } morse_code_t;

  localparam morse_code_t CODE_A = {4'b0100, 3'd2};
  localparam morse_code_t CODE_B = {4'b1000, 3'd4};
  localparam morse_code_t CODE_C = {4'b1010, 3'd4};
  localparam morse_code_t CODE_D = {4'b1000, 3'd3};
  localparam morse_code_t CODE_E = {4'b0000, 3'd1};
  localparam morse_code_t CODE_F = {4'b0010, 3'd4};
  localparam morse_code_t CODE_G = {4'b1100, 3'd3};
  localparam morse_code_t CODE_H = {4'b0000, 3'd4};

endpackage

// File: rtl/morse_rom.sv
// Combinational letter lookup: A..H select to Morse pattern and length.
module morse_rom
  import morse_pkg::*;
(
  input  logic [LETTER_W-1:0] letter_i,
  output morse_code_t         code_c_o
);

  always_comb begin
    code_c_o = CODE_E;
    case (letter_i)
      3'd0: code_c_o = CODE_A;
      3'd1: code_c_o = CODE_B;
      3'd2: code_c_o = CODE_C;
      3'd3: code_c_o = CODE_D;
      3'd4: code_c_o = CODE_E;
      3'd5: code_c_o = CODE_F;
      3'd6: code_c_o = CODE_G;
      3'd7: code_c_o = CODE_H;
    endcase
  end

endmodule

// File: rtl/morse_letter_sequencer.sv
// Plays one latched letter on LED_OUT, pacing elements with the external unit timer.
// Optional MORSE_REPEAT_EN: replay the letter after a 3-unit gap while START stays high.
module morse_letter_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned DOT_UNITS  = 1,
  parameter int unsigned DASH_UNITS = 3,
  parameter int unsigned GAP_UNITS  = 1
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                START,
  input  logic [LETTER_W-1:0] LETTER,
  input  logic [CNT_W-1:0]    half_sec_count,
  output logic                TIMER_EN,
  output logic                LED_OUT,
  output logic                BUSY,
  output logic                DONE
);

  state_t             state_q, state_d;
  next_el_t           nxt_q, nxt_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   sync1_q, sync2_q;
  logic               timer_en_q, timer_en_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  morse_code_t        rom_code;
  logic [IDX_W-1:0]   bit_sel;
  logic [CNT_W-1:0]   sym_target;
  logic               cnt_stable;
  logic               last_sym;
  logic               sym_done;
  logic               gap_done;
`ifdef MORSE_REPEAT_EN
  logic               lgap_done;
`endif

  morse_rom u_rom (
    .letter_i (LETTER),
    .code_c_o (rom_code)
  );

  // Count is trusted only when both sync stages agree; stages are held clear while
  // the timer is disabled so a stale or stray count never leaks into the next element.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (!timer_en_q) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= half_sec_count;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    bit_sel    = 2'd3 - idx_q;
    sym_target = pat_q[bit_sel] ? CNT_W'(DASH_UNITS) : CNT_W'(DOT_UNITS);
    cnt_stable = (sync1_q == sync2_q);
    last_sym   = ({1'b0, idx_q} == (len_q - 3'd1));
    sym_done   = cnt_stable && (sync2_q == sym_target);
    gap_done   = cnt_stable && (sync2_q == CNT_W'(GAP_UNITS));
`ifdef MORSE_REPEAT_EN
    lgap_done  = cnt_stable && (sync2_q == CNT_W'(LETTER_GAP_UNITS));
`endif
  end

  // Next state and datapath updates; outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          pat_d   = rom_code.pattern;
          len_d   = rom_code.length;
          idx_d   = '0;
          nxt_d   = NXT_ON;
          state_d = RESTART;
        end
      end
      RESTART: begin
        case (nxt_q)
          NXT_ON:  state_d = ON;
          NXT_OFF: state_d = OFF;
`ifdef MORSE_REPEAT_EN
          NXT_LGAP: state_d = LETTER_GAP;
`endif
          default: state_d = IDLE;
        endcase
      end
      ON: begin
        if (sym_done) begin
          if (last_sym) begin
`ifdef MORSE_REPEAT_EN
            if (START) begin
              nxt_d   = NXT_LGAP;
              state_d = RESTART;
            end else begin
              state_d = FIN;
            end
`else
            state_d = FIN;
`endif
          end else begin
            nxt_d   = NXT_OFF;
            state_d = RESTART;
          end
        end
      end
      OFF: begin
        if (gap_done) begin
          idx_d   = idx_q + 2'd1;
          nxt_d   = NXT_ON;
          state_d = RESTART;
        end
      end
      LETTER_GAP: begin
`ifdef MORSE_REPEAT_EN
        if (lgap_done) begin
          idx_d   = '0;
          nxt_d   = NXT_ON;
          state_d = RESTART;
        end
`else
        state_d = IDLE;
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    timer_en_d = (state_d inside {ON, OFF, LETTER_GAP});
    led_d      = (state_d == ON);
    busy_d     = (state_d inside {RESTART, ON, OFF, LETTER_GAP});
    done_d     = (state_d == FIN);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      nxt_q      <= NXT_ON;
      pat_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      timer_en_q <= 1'b0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      timer_en_q <= timer_en_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign TIMER_EN = timer_en_q;
  assign LED_OUT  = led_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Bench for morse_letter_sequencer: a unit timer model (4 clocks per unit) feeds the
// count; LED run lengths, latency and handshake are checked per letter.
module tb_morse_letter_sequencer;

  // With a 4-clock unit, 2-flop sync and one decision cycle: on = 4u+2 clocks,
  // inter-symbol low = RESTART + (4g+2) + RESTART.
  localparam int DOT_HI  = 6;
  localparam int DASH_HI = 14;
  localparam int GAP_LO  = 8;
  localparam int LAT     = 2;
  localparam int MAX_CYC = 300;

  logic       CLOCK_50;
  logic       RESET;
  logic       START;
  logic [2:0] LETTER;
  wire  [2:0] half_sec_count;
  logic       TIMER_EN;
  logic       LED_OUT;
  logic       BUSY;
  logic       DONE;

  logic [2:0] tmr_cnt;
  logic [1:0] tmr_pre;
  logic       ovr_en;
  logic [2:0] ovr_val;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic [2:0] letter;
    logic [2:0] chg_letter;
    logic [7:0] chg_at;
    logic       glitch;
    logic       stray;
    logic [2:0] exp_len;
    logic [3:0] exp_dash;
  } vec_t;

  vec_t vecs[11];

  int   r_nhi;
  int   r_hi[4];
  int   r_gap[4];
  int   r_lat;
  int   r_ndone;
  int   r_hs_err;
  int   r_en_runs;
  int   r_en_max;
  int   r_timeout;

  morse_letter_sequencer dut (
    .CLOCK_50       (CLOCK_50),
    .RESET          (RESET),
    .START          (START),
    .LETTER         (LETTER),
    .half_sec_count (half_sec_count),
    .TIMER_EN       (TIMER_EN),
    .LED_OUT        (LED_OUT),
    .BUSY           (BUSY),
    .DONE           (DONE)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Half-second timer stand-in: clears while disabled, one unit every 4 clocks.
  always @(negedge CLOCK_50) begin
    if (!TIMER_EN) begin
      tmr_pre <= 2'd0;
      tmr_cnt <= 3'd0;
    end else if (tmr_pre == 2'd3) begin
      tmr_pre <= 2'd0;
      tmr_cnt <= tmr_cnt + 3'd1;
    end else begin
      tmr_pre <= tmr_pre + 2'd1;
    end
  end

  assign half_sec_count = ovr_en ? ovr_val : tmr_cnt;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [2:0] l, input logic [2:0] cl, input logic [7:0] ca,
                              input logic g, input logic s, input logic [2:0] n,
                              input logic [3:0] d);
    vec_t v;
    v.letter = l; v.chg_letter = cl; v.chg_at = ca; v.glitch = g; v.stray = s;
    v.exp_len = n; v.exp_dash = d;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_letter(input vec_t v);
    logic prev_led, prev_busy, glitched, finished;
    int   hi_run, lo_run, en_cur, done_c;
    r_nhi = 0; r_lat = -1; r_ndone = 0; r_hs_err = 0; r_en_runs = 0; r_en_max = 0;
    r_timeout = 1;
    for (int i = 0; i < 4; i++) begin r_hi[i] = 0; r_gap[i] = 0; end
    prev_led = 1'b0; prev_busy = 1'b0; glitched = 1'b0; finished = 1'b0;
    hi_run = 0; lo_run = 0; en_cur = 0; done_c = 0;
    @(negedge CLOCK_50); #1;
    LETTER = v.letter;
    START  = 1'b1;
    for (int c = 1; c <= MAX_CYC && !finished; c++) begin
      @(negedge CLOCK_50); #1;
      ovr_en = 1'b0;
      if (c == 1) begin
        START = 1'b0;
        if (!BUSY) r_hs_err++;
      end
      if (v.chg_at != 8'd0 && c == int'(v.chg_at)) LETTER = v.chg_letter;
      if (LED_OUT) begin
        if (!prev_led) begin
          if (r_nhi == 0) r_lat = c;
          else if (r_nhi <= 4) r_gap[r_nhi-1] = lo_run;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_led) begin
          if (r_nhi < 4) r_hi[r_nhi] = hi_run;
          r_nhi++;
          lo_run = 0;
        end
        lo_run++;
      end
      if (BUSY && !TIMER_EN) en_cur++;
      else begin
        if (en_cur > 0) begin
          r_en_runs++;
          if (en_cur > r_en_max) r_en_max = en_cur;
        end
        en_cur = 0;
      end
      if (DONE) begin
        r_ndone++;
        if (BUSY || !prev_busy || !prev_led) r_hs_err++;
        done_c = c;
        r_timeout = 0;
      end
      if (r_ndone > 0 && c >= done_c + 3) finished = 1'b1;
      if (v.stray && BUSY && !TIMER_EN) begin ovr_en = 1'b1; ovr_val = 3'd5; end
      if (v.glitch && !glitched && LED_OUT && tmr_cnt == 3'd1) begin
        ovr_en = 1'b1; ovr_val = 3'd3; glitched = 1'b1;
      end
      prev_led  = LED_OUT;
      prev_busy = BUSY;
    end
    ovr_en = 1'b0;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    int n;
    n = int'(v.exp_len);
    chk($sformatf("v%0d timeout", idx), r_timeout, 0);
    chk($sformatf("v%0d symbols", idx), r_nhi, n);
    for (int i = 0; i < n; i++)
      chk($sformatf("v%0d on_len[%0d]", idx, i), r_hi[i], v.exp_dash[3-i] ? DASH_HI : DOT_HI);
    for (int i = 0; i < n - 1; i++)
      chk($sformatf("v%0d gap_len[%0d]", idx, i), r_gap[i], GAP_LO);
    chk($sformatf("v%0d latency", idx), r_lat, LAT);
    chk($sformatf("v%0d done_pulses", idx), r_ndone, 1);
    chk($sformatf("v%0d handshake_err", idx), r_hs_err, 0);
    chk($sformatf("v%0d restart_cnt", idx), r_en_runs, 2 * n - 1);
    chk($sformatf("v%0d restart_len", idx), r_en_max, 1);
  endtask

  initial begin
    int w;
    n_tests = 0; n_fail = 0;
    RESET = 1'b1; START = 1'b0; LETTER = 3'd0; ovr_en = 1'b0; ovr_val = 3'd0;

    vecs[0]  = mk(3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 3'd2, 4'b0100);
    vecs[1]  = mk(3'd1, 3'd0, 8'd0, 1'b0, 1'b0, 3'd4, 4'b1000);
    vecs[2]  = mk(3'd2, 3'd0, 8'd0, 1'b0, 1'b0, 3'd4, 4'b1010);
    vecs[3]  = mk(3'd3, 3'd0, 8'd0, 1'b0, 1'b0, 3'd3, 4'b1000);
    vecs[4]  = mk(3'd4, 3'd0, 8'd0, 1'b0, 1'b0, 3'd1, 4'b0000);
    vecs[5]  = mk(3'd5, 3'd0, 8'd0, 1'b0, 1'b0, 3'd4, 4'b0010);
    vecs[6]  = mk(3'd6, 3'd0, 8'd0, 1'b0, 1'b0, 3'd3, 4'b1100);
    vecs[7]  = mk(3'd7, 3'd0, 8'd0, 1'b0, 1'b0, 3'd4, 4'b0000);
    vecs[8]  = mk(3'd4, 3'd6, 8'd3, 1'b0, 1'b0, 3'd1, 4'b0000);
    vecs[9]  = mk(3'd1, 3'd0, 8'd0, 1'b1, 1'b0, 3'd4, 4'b1000);
    vecs[10] = mk(3'd0, 3'd0, 8'd0, 1'b0, 1'b1, 3'd2, 4'b0100);

    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("reset LED_OUT", int'(LED_OUT), 0);
    chk("reset TIMER_EN", int'(TIMER_EN), 0);
    chk("reset BUSY", int'(BUSY), 0);
    chk("reset DONE", int'(DONE), 0);
    RESET = 1'b0;
    @(negedge CLOCK_50); #1;
    chk("idle BUSY", int'(BUSY), 0);

    for (int i = 0; i < 11; i++) begin
      run_letter(vecs[i]);
      check_vec(i, vecs[i]);
    end

    // Asynchronous reset in the middle of B's opening dash.
    @(negedge CLOCK_50); #1;
    LETTER = 3'd1; START = 1'b1;
    @(negedge CLOCK_50); #1;
    START = 1'b0;
    w = 0;
    while (!LED_OUT && w < 20) begin @(negedge CLOCK_50); #1; w++; end
    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("rst in dash LED before", int'(LED_OUT), 1);
    RESET = 1'b1;
    #2;
    chk("rst async LED_OUT", int'(LED_OUT), 0);
    chk("rst async TIMER_EN", int'(TIMER_EN), 0);
    chk("rst async BUSY", int'(BUSY), 0);
    @(negedge CLOCK_50); #1;
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    #1;
    chk("post rst idle BUSY", int'(BUSY), 0);
    run_letter(vecs[4]);
    check_vec(100, vecs[4]);

`ifdef MORSE_REPEAT_EN
    begin
      int rises, dn, gap, lo;
      logic pl;
      rises = 0; dn = 0; gap = 0; lo = 0; pl = 1'b0;
      @(negedge CLOCK_50); #1;
      LETTER = 3'd4; START = 1'b1;
      for (int c = 0; c < 200 && rises < 3; c++) begin
        @(negedge CLOCK_50); #1;
        if (DONE) dn++;
        if (LED_OUT && !pl) begin
          if (rises > 0) gap = lo;
          rises++;
        end
        if (!LED_OUT) lo = (pl ? 0 : lo) + 1;
        pl = LED_OUT;
      end
      chk("repeat dots", rises, 3);
      chk("repeat letter gap", gap, 16);
      chk("repeat no DONE", dn, 0);
      chk("repeat BUSY", int'(BUSY), 1);
      START = 1'b0;
      rises = 0; dn = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge CLOCK_50); #1;
        if (DONE) dn++;
        if (LED_OUT && !pl) rises++;
        pl = LED_OUT;
      end
      chk("repeat stop DONE", dn, 1);
      chk("repeat stop extra dots", rises, 0);
    end
`else
    // START held through FIN: no acceptance alongside DONE, re-accept one cycle later.
    @(negedge CLOCK_50); #1;
    LETTER = 3'd4; START = 1'b1;
    w = 0;
    while (!DONE && w < 100) begin @(negedge CLOCK_50); #1; w++; end
    chk("held DONE seen", int'(DONE), 1);
    chk("held BUSY at DONE", int'(BUSY), 0);
    @(negedge CLOCK_50); #1;
    chk("held idle DONE", int'(DONE), 0);
    chk("held idle BUSY", int'(BUSY), 0);
    @(negedge CLOCK_50); #1;
    chk("held reaccept BUSY", int'(BUSY), 1);
    START = 1'b0;
    w = 0;
    while (!DONE && w < 100) begin @(negedge CLOCK_50); #1; w++; end
    chk("held second DONE", int'(DONE), 1);
`endif

    repeat (3) @(negedge CLOCK_50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
